// File: rtl/switch_out_scheduler.sv
// rtl/switch_out_scheduler.sv - per-output round-robin packet scheduler for the 4-port switch
// Optional forced release after MAX_HOLD grant cycles: define SCHED_TIMEOUT_EN.
module switch_out_scheduler #(
    parameter int NUM_PORTS = 4,
    parameter int SEL_W     = $clog2(NUM_PORTS),
    parameter int MAX_HOLD  = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_PORTS-1:0]           i_req,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] i_req_dst,
    output logic [NUM_PORTS-1:0]           o_grant,
    output logic [NUM_PORTS*SEL_W-1:0]     o_mux_sel,
    output logic [NUM_PORTS-1:0]           o_active,
    output logic [NUM_PORTS-1:0]           o_dst_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]           r_state [NUM_PORTS];
    logic [SEL_W-1:0]     r_ptr   [NUM_PORTS];
    logic [SEL_W-1:0]     r_sel   [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_grant;
    logic [NUM_PORTS-1:0] r_active;
    logic [NUM_PORTS-1:0] r_dst_err;

    logic [NUM_PORTS-1:0] w_dst_ok;
    logic [NUM_PORTS-1:0] w_cand  [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_found;
    logic [SEL_W-1:0]     w_win   [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_release;
    logic [NUM_PORTS-1:0] w_timeout;

`ifdef SCHED_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0]    r_hold [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_mask [NUM_PORTS];
`endif

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_dst_ok[i] = $onehot(i_req_dst[i*NUM_PORTS +: NUM_PORTS]);
        end
    end

    // An input already holding a grant is never a candidate, so one input never owns two outputs.
    always_comb begin : p_arb
        int idx;
        idx = 0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_cand[o][i] = i_req[i] && w_dst_ok[i] && i_req_dst[i*NUM_PORTS + o] && !r_grant[i];
            end
`ifdef SCHED_TIMEOUT_EN
            if ((w_cand[o] & ~r_mask[o]) != '0) begin
                w_cand[o] = w_cand[o] & ~r_mask[o];
            end
`endif
            w_found[o] = 1'b0;
            w_win[o]   = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = (int'(r_ptr[o]) + k) % NUM_PORTS;
                if (!w_found[o] && w_cand[o][idx]) begin
                    w_found[o] = 1'b1;
                    w_win[o]   = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
`ifdef SCHED_TIMEOUT_EN
            w_timeout[o] = (r_state[o] == S_BUSY) && (r_hold[o] == HOLD_W'(MAX_HOLD));
`else
            w_timeout[o] = 1'b0;
`endif
            w_release[o] = (r_state[o] == S_BUSY) && (!i_req[r_sel[o]] || w_timeout[o]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant   <= '0;
            r_active  <= '0;
            r_dst_err <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_state[o] <= S_IDLE;
                r_ptr[o]   <= '0;
                r_sel[o]   <= '0;
`ifdef SCHED_TIMEOUT_EN
                r_hold[o]  <= '0;
                r_mask[o]  <= '0;
`endif
            end
        end else begin
            r_dst_err <= i_req & ~w_dst_ok;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (r_state[o] == S_BUSY) begin
                    if (w_release[o]) begin
                        // Staying IDLE for one edge gives the mandatory bubble between packets.
                        r_state[o]         <= S_IDLE;
                        r_active[o]        <= 1'b0;
                        r_grant[r_sel[o]]  <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
                        if (w_timeout[o]) begin
                            r_mask[o] <= NUM_PORTS'(1) << r_sel[o];
                        end
                    end else begin
                        r_hold[o] <= r_hold[o] + HOLD_W'(1);
`endif
                    end
                end else if (w_found[o]) begin
                    r_state[o]        <= S_BUSY;
                    r_sel[o]          <= w_win[o];
                    r_ptr[o]          <= (w_win[o] == SEL_W'(NUM_PORTS - 1)) ? '0 : w_win[o] + SEL_W'(1);
                    r_grant[w_win[o]] <= 1'b1;
                    r_active[o]       <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
                    r_hold[o]         <= HOLD_W'(1);
                    r_mask[o]         <= '0;
`endif
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            o_mux_sel[o*SEL_W +: SEL_W] = r_sel[o];
        end
    end

    assign o_grant   = r_grant;
    assign o_active  = r_active;
    assign o_dst_err = r_dst_err;

endmodule

// File: tb/tb_switch_out_scheduler.sv
// tb/tb_switch_out_scheduler.sv - directed scoreboard bench for switch_out_scheduler
module tb_switch_out_scheduler;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [3:0]  i_req;
    logic [15:0] i_req_dst;
    logic [3:0]  o_grant;
    logic [7:0]  o_mux_sel;
    logic [3:0]  o_active;
    logic [3:0]  o_dst_err;

    always #5 i_clk = ~i_clk;

    switch_out_scheduler dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req),
        .i_req_dst (i_req_dst),
        .o_grant   (o_grant),
        .o_mux_sel (o_mux_sel),
        .o_active  (o_active),
        .o_dst_err (o_dst_err)
    );

    typedef struct {
        logic [3:0] g;
        logic [3:0] a;
        logic [3:0] e;
        logic [7:0] s;
        logic [7:0] m;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] req, input logic [15:0] dst,
                       input logic [3:0] eg, input logic [3:0] ea, input logic [3:0] ee,
                       input logic [7:0] es, input logic [7:0] em, input string tag);
        exp_t e;
        @(negedge i_clk);
        i_req     = req;
        i_req_dst = dst;
        e.g = eg; e.a = ea; e.e = ee; e.s = es; e.m = em; e.tag = tag;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "/grant"},   {4'h0, o_grant},   {4'h0, e.g});
        chk({e.tag, "/active"},  {4'h0, o_active},  {4'h0, e.a});
        chk({e.tag, "/dst_err"}, {4'h0, o_dst_err}, {4'h0, e.e});
        if (e.m != 8'h00) chk({e.tag, "/mux_sel"}, o_mux_sel & e.m, e.s & e.m);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        i_rst_n   = 1'b0;
        i_req     = 4'b0001;
        i_req_dst = 16'h0004;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset/grant",  {4'h0, o_grant},  8'h00);
        chk("reset/active", {4'h0, o_active}, 8'h00);
        chk("reset/err",    {4'h0, o_dst_err}, 8'h00);
        chk("reset/sel",    o_mux_sel,        8'h00);
        @(negedge i_clk);
        i_req   = 4'b0000;
        i_rst_n = 1'b1;

        cyc(4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, "idle");
        cyc(4'b0001, 16'h0004, 4'b0001, 4'b0100, 4'b0000, 8'h00, 8'h30, "single_grant");
        cyc(4'b0001, 16'h0004, 4'b0001, 4'b0100, 4'b0000, 8'h00, 8'h30, "single_hold");
        cyc(4'b0001, 16'h0008, 4'b0001, 4'b0100, 4'b0000, 8'h00, 8'h30, "single_dst_latched");
        cyc(4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, "single_release");

        cyc(4'b1011, 16'h2022, 4'b0001, 4'b0010, 4'b0000, 8'h00, 8'h0C, "rr_p0");
        cyc(4'b1011, 16'h2022, 4'b0001, 4'b0010, 4'b0000, 8'h00, 8'h0C, "rr_p0");
        cyc(4'b1011, 16'h2022, 4'b0001, 4'b0010, 4'b0000, 8'h00, 8'h0C, "rr_p0");
        cyc(4'b1010, 16'h2022, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, "rr_bubble0");
        cyc(4'b1011, 16'h2022, 4'b0010, 4'b0010, 4'b0000, 8'h04, 8'h0C, "rr_p1");
        cyc(4'b1011, 16'h2022, 4'b0010, 4'b0010, 4'b0000, 8'h04, 8'h0C, "rr_p1");
        cyc(4'b1011, 16'h2022, 4'b0010, 4'b0010, 4'b0000, 8'h04, 8'h0C, "rr_p1");
        cyc(4'b1001, 16'h2022, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, "rr_bubble1");
        cyc(4'b1011, 16'h2022, 4'b1000, 4'b0010, 4'b0000, 8'h0C, 8'h0C, "rr_p3");
        cyc(4'b1011, 16'h2022, 4'b1000, 4'b0010, 4'b0000, 8'h0C, 8'h0C, "rr_p3");
        cyc(4'b1011, 16'h2022, 4'b1000, 4'b0010, 4'b0000, 8'h0C, 8'h0C, "rr_p3");
        cyc(4'b0011, 16'h2022, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, "rr_bubble3");
        cyc(4'b1011, 16'h2022, 4'b0001, 4'b0010, 4'b0000, 8'h00, 8'h0C, "rr_p0_again");
        cyc(4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, "rr_done");

        cyc(4'b0101, 16'h0108, 4'b0101, 4'b1001, 4'b0000, 8'h02, 8'hC3, "parallel");
        cyc(4'b0100, 16'h0108, 4'b0100, 4'b0001, 4'b0000, 8'h02, 8'h03, "parallel_rel3");
        cyc(4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, "parallel_done");

        cyc(4'b0010, 16'h0060, 4'b0000, 4'b0000, 4'b0010, 8'h00, 8'h00, "bad_multi");
        cyc(4'b0010, 16'h0060, 4'b0000, 4'b0000, 4'b0010, 8'h00, 8'h00, "bad_multi_hold");
        cyc(4'b0110, 16'h0060, 4'b0000, 4'b0000, 4'b0110, 8'h00, 8'h00, "bad_zero");
        cyc(4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, "bad_clear");

        cyc(4'b1000, 16'h1000, 4'b1000, 4'b0001, 4'b0000, 8'h03, 8'h03, "pre_reset");
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_reset/grant",  {4'h0, o_grant},  8'h00);
        chk("async_reset/active", {4'h0, o_active}, 8'h00);
        chk("async_reset/sel",    o_mux_sel,        8'h00);
        @(negedge i_clk);
        i_req   = 4'b0000;
        i_rst_n = 1'b1;
        cyc(4'b1100, 16'h1100, 4'b0100, 4'b0001, 4'b0000, 8'h02, 8'h03, "post_reset");
        cyc(4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, "post_reset_done");

`ifdef SCHED_TIMEOUT_EN
        cyc(4'b0001, 16'h0044, 4'b0001, 4'b0100, 4'b0000, 8'h00, 8'h30, "to_grant0");
        for (int k = 0; k < 15; k++) begin
            cyc(4'b0011, 16'h0044, 4'b0001, 4'b0100, 4'b0000, 8'h00, 8'h30, "to_hold0");
        end
        cyc(4'b0011, 16'h0044, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, "to_forced");
        cyc(4'b0011, 16'h0044, 4'b0010, 4'b0100, 4'b0000, 8'h10, 8'h30, "to_grant1");
        cyc(4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, "to_done");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_out_scheduler.md
Name: switch_out_scheduler

Overview:
- Registered, per-output round-robin scheduler for the 4-port switch.
- Each input port presents a request plus a one-hot destination. For each output, the block grants one requester and holds the grant for the whole packet, i.e. while the request stays asserted.
- Drives the per-input grant bus and the per-output mux select/active signals that steer the output muxes.
- Sits between the switch_port instances and the output muxes, replacing the fixed-priority grant path.

Parameters:
- NUM_PORTS, 4, number of input ports and number of output ports.
- SEL_W, $clog2(NUM_PORTS) = 2, width of each mux select field.
- MAX_HOLD, 16, grant cycle limit per packet; used only when SCHED_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous active-low.
- req  input  NUM_PORTS  req[i]=1: input i has a packet pending or in progress.
- req_dst  input  NUM_PORTS*NUM_PORTS  bits [i*NUM_PORTS +: NUM_PORTS] = one-hot target output of input i.
- grant  output  NUM_PORTS  grant[i]=1: input i currently owns its target output.
- mux_sel  output  NUM_PORTS*SEL_W  bits [o*SEL_W +: SEL_W] = input index driving output o.
- active  output  NUM_PORTS  active[o]=1: output o carries a granted packet this cycle.
- dst_err  output  NUM_PORTS  1-cycle pulse; input i requested with a zero or multi-hot req_dst.

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: grant=0, mux_sel=0, active=0, dst_err=0. All per-output FSMs are in IDLE and all round-robin pointers rr_ptr[o]=0.
- All outputs are registered. There is no combinational path from req or req_dst to any output.
- Per-output FSM, two states:
  - IDLE -> BUSY at the next edge when at least one valid candidate exists.
  - A valid candidate is input i with req[i]=1, req_dst of i one-hot with bit o set, and grant[i]=0.
  - BUSY -> IDLE at the next edge after the owner's req drops.
- Winner selection: first valid candidate scanning i = rr_ptr[o], rr_ptr[o]+1, ... modulo NUM_PORTS.
- On entering BUSY with winner w:
  - grant[w]=1, mux_sel[o]=w, active[o]=1, all at the same edge.
  - rr_ptr[o] <= (w+1) mod NUM_PORTS.
- Latency: request at cycle N -> grant and active visible at cycle N+1.
- Release: owner req=0 at cycle M -> grant[w]=0 and active[o]=0 at M+1.
  - mux_sel[o] keeps its last value; don't-care while active=0.
  - Output o cannot be re-granted before M+2, giving a mandatory one-cycle bubble between packets.
- While BUSY:
  - req_dst changes from the owner are ignored; the destination is latched at grant.
  - Other requesters for o wait, with no grant.
- Independent outputs may be granted in the same cycle. An input holds at most one grant, because req_dst is one-hot.
- Bad destination: req[i]=1 with req_dst zero or multi-hot -> dst_err[i] pulses 1 cycle later and input i is not considered.
  - dst_err re-pulses every cycle while the condition persists.
- Reset mid-packet: all grants, active, and pointers clear immediately (asynchronous). The first grant after reset release follows the normal N+1 latency.
- Simultaneous events: one output's release and another output's new grant in the same cycle are independent. Release and a new request for the same output obey the bubble rule.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Defined:
  - A per-output hold counter loads 1 on grant and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD, the FSM forces BUSY -> IDLE even if the owner's req is still 1, and clears grant and active.
  - The forced-out input is masked from output o for one arbitration round: it is skipped if any other valid candidate exists.
- Not defined: no counter and no forced release; a grant is held until req drops.

Test Plan:
- Single request: reset, then req=4'b0001, req_dst input0=4'b0100 at cycle 5 -> cycle 6 grant=0001, active=0100, mux_sel output2=0. req0 dropped at cycle 10 -> cycle 11 grant=0, active=0.
- Contention rotation:
  - Inputs 0,1,3 all target output1 continuously, each dropping req for 1 cycle after a 3-cycle packet.
  - Required grant order: 0,1,3,0, with exactly one idle cycle between packets on active[1].
- Parallel outputs: input0->output3, input2->output0, both requesting at cycle 5 -> cycle 6 grant=0101, active=1001, mux_sel output3=0, mux_sel output0=2.
- Bad destination: req=0010 with req_dst input1=4'b0110 -> dst_err=0010 next cycle and every following cycle while held; grant stays 0.
- Reset mid-packet: input3 granted output0, rst_n=0 asynchronously mid-cycle -> grant, active, mux_sel read 0 immediately. After release, a new request from input2 is granted first, since rr_ptr was reset to 0.
- SCHED_TIMEOUT_EN, MAX_HOLD=16:
  - input0 holds req to output2 indefinitely, input1 also requests output2.
  - Required: grant[0] for exactly 16 cycles, 1 bubble, then grant[1].
